clock_sel_ctrl: RTL
===================

Name: clock_sel_ctrl

Overview:
- Upstream sequencer that produces the 2-bit select driving the glitch-free clock switch (800M/500M/1000M).
- Accepts select requests over a valid/ready handshake and rejects the reserved code.
- After each real change it holds off further requests for a fixed settle window, so the downstream switch finishes its handover before the select moves again.
- Runs on an always-on reference clock.

Parameters:
- SETTLE_CYC, 16, clk cycles the select is held after a change before the next request is accepted; must be >= 1.
- CNT_W, 8, width of the switch-event counter.
- DEFAULT_SEL, 2'b00, select value applied at reset (800M).

Ports:
- clk  in  1  reference clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_sel  in  2  requested select code.
- req_ready  out  1  request accepted when req_valid && req_ready.
- rsp_valid  out  1  one-cycle completion pulse, one per accepted request.
- rsp_err  out  1  qualifies rsp_valid: 1 = rejected (reserved code); 0 when rsp_valid=0.
- clk_sel  out  2  select to the clock switch; registered.
- busy  out  1  high while in SETTLE.
- switch_cnt  out  CNT_W  number of real select changes since reset; saturating.

Behaviour:
- Reset (sync, rst=1 at a clk edge), with all values visible the following cycle:
  - state=IDLE
  - clk_sel=DEFAULT_SEL
  - req_ready=1, rsp_valid=0, rsp_err=0, busy=0
  - switch_cnt=0
  - settle counter=0
- Reset has priority over every other event. Reset during SETTLE aborts the settle, forces clk_sel=DEFAULT_SEL and emits no rsp_valid for the aborted request.
- States: IDLE, SETTLE. All outputs are registered, and req_ready and busy are decoded from the registered state.
- IDLE: req_ready=1, busy=0. On an accept at edge T:
  - req_sel==2'b11: rsp_valid=1 and rsp_err=1 in cycle T+1. clk_sel and switch_cnt unchanged. Stay IDLE.
  - req_sel==clk_sel: rsp_valid=1 and rsp_err=0 in cycle T+1. No settle, no count. Stay IDLE.
  - Otherwise, in cycle T+1: clk_sel=req_sel, state=SETTLE, settle counter=SETTLE_CYC-1, switch_cnt+1 (held at all-ones when saturated).
  - IDLE accepts back-to-back: a new request can be accepted in the same cycle a non-settling rsp_valid is high.
- SETTLE: req_ready=0, busy=1, clk_sel stable.
  - The counter decrements each cycle. In the cycle it is 0, the next state is IDLE.
  - SETTLE therefore lasts exactly SETTLE_CYC cycles (T+1 .. T+SETTLE_CYC).
  - In cycle T+SETTLE_CYC+1: state=IDLE, req_ready=1, rsp_valid=1, rsp_err=0.
  - A request can be accepted in that same cycle.
- Handshake rules:
  - req_valid while req_ready=0 is ignored and not queued. The requester must hold req_valid until accept.
  - req_sel is sampled only at accept.
- Latency (accept to rsp_valid): 1 cycle for non-change or error; SETTLE_CYC+1 cycles for a change.
- rsp_valid is never high for two consecutive cycles from a single request.
- clk_sel changes at most once per SETTLE_CYC+1 cycles and never takes the value 2'b11.

Decomposition:
- Package clock_sel_pkg holds:
  - select encodings: SEL_800M=2'b00, SEL_500M=2'b01, SEL_1000M=2'b10, SEL_RSVD=2'b11
  - state encoding: IDLE, SETTLE
  - counter width helper: clog2 of SETTLE_CYC
- One natural sub-module, clock_sel_settle_timer: load/decrement down-counter with a done flag. Everything else stays in a single FSM module.

Test Plan (SETTLE_CYC=16, CNT_W=8):
- Reset: hold rst=1 for 3 cycles, release -> clk_sel=00, req_ready=1, busy=0, switch_cnt=0, rsp_valid=0.
- Change: req_sel=01 accepted at T -> clk_sel=01 at T+1; busy=1 and req_ready=0 for T+1..T+16; rsp_valid=1, rsp_err=0, req_ready=1 at T+17; switch_cnt=1.
- Blocked request: during SETTLE hold req_valid=1 with req_sel=10 -> not accepted until T+17. Accepted at T+17 -> clk_sel=10 at T+18, switch_cnt=2.
- Reserved and no-op codes: with clk_sel=10, req_sel=11 -> rsp_valid+rsp_err at T+1, clk_sel stays 10. Then req_sel=10 -> rsp_valid, rsp_err=0 at T+1, busy never asserts, switch_cnt unchanged.
- Reset mid-settle: accept 00->10 change, assert rst at T+5 -> next cycle clk_sel=00, busy=0, switch_cnt=0, no rsp_valid follows.
- Saturation: with CNT_W=2, perform 5 alternating changes 00<->01 -> switch_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/clock_sel_pkg.sv
// =============================================================================
// Module  : clock_sel_pkg
// Brief   : Shared encodings and helpers for the clock-select sequencer.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package clock_sel_pkg;

    localparam logic [1:0] SEL_800M  = 2'b00;
    localparam logic [1:0] SEL_500M  = 2'b01;
    localparam logic [1:0] SEL_1000M = 2'b10;
    localparam logic [1:0] SEL_RSVD  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    // Width that holds SETTLE_CYC-1; never collapses to zero bits.
    function automatic int settle_cnt_w(input int settle_cyc);
        return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_sel_settle_timer.sv
// =============================================================================
// Module  : clock_sel_settle_timer
// Brief   : Loadable down-counter that stops at zero and flags done.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module clock_sel_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/clock_sel_ctrl.sv
// =============================================================================
// Module  : clock_sel_ctrl
// Brief   : Handshaked clock-select sequencer with post-change settle hold-off.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module clock_sel_ctrl
    import clock_sel_pkg::*;
#(
    parameter int         SETTLE_CYC  = 16,
    parameter int         CNT_W       = 8,
    parameter logic [1:0] DEFAULT_SEL = 2'b00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_sel,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [1:0]       clk_sel,
    output logic             busy,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int            TW       = settle_cnt_w(SETTLE_CYC);
    localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [1:0]       clk_sel_q, clk_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] switch_cnt_q, switch_cnt_d;
    logic             timer_load;
    logic             timer_done;

    clock_sel_settle_timer #(
        .W (TW)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (LOAD_VAL),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        clk_sel_d    = clk_sel_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        switch_cnt_d = switch_cnt_q;
        timer_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_sel == SEL_RSVD) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_sel == clk_sel_q) begin
                        rsp_valid_d = 1'b1;
                    end else begin
                        clk_sel_d  = req_sel;
                        state_d    = ST_SETTLE;
                        timer_load = 1'b1;
                        if (switch_cnt_q != '1) begin
                            switch_cnt_d = switch_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_SETTLE: begin
                // Completion for the change is reported as the FSM returns to IDLE.
                if (timer_done) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clk_sel_q    <= DEFAULT_SEL;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            switch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            clk_sel_q    <= clk_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SETTLE);
    assign clk_sel    = clk_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign switch_cnt = switch_cnt_q;

endmodule

`default_nettype wire
